// File: rtl/btn_repeat_pkg.sv
// Shared definitions for the button event generator: FSM states and the
// default time-base width shared with the debouncer.
package btn_repeat_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StHold   = 2'd1,
    StRepeat = 2'd2
  } state_e;

  // 2^19 cycles is ~10.5 ms at 50 MHz.
  localparam int unsigned TickNDefault = 19;

endpackage

// File: rtl/btn_repeat_if.sv
// Debounced level in, one-cycle event pulses out.
// "release" is a SystemVerilog keyword, so the release pulse is named rel.
interface btn_repeat_if;
  logic db;
  logic press;
  logic rel;
  logic rpt;
  logic held;

  modport master (output db, input press, rel, rpt, held);
  modport slave  (input db, output press, rel, rpt, held);
endinterface

// File: rtl/btn_repeat_tick_gen.sv
// Free-running prescaler; tick is high for the one cycle the counter is all-ones.
module btn_repeat_tick_gen
  import btn_repeat_pkg::*;
#(
  parameter int unsigned TICK_N = TickNDefault
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [TICK_N-1:0] pre_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + TICK_N'(1);
    end
  end

  assign tick = &pre_q;

endmodule

// File: rtl/btn_repeat.sv
// Turns a debounced button level into press / release / typematic repeat pulses
// plus a held level while auto-repeating.
module btn_repeat
  import btn_repeat_pkg::*;
#(
  parameter int unsigned TICK_N       = TickNDefault,
  parameter int unsigned HOLD_TICKS   = 50,
  parameter int unsigned REPEAT_TICKS = 10,
  parameter int unsigned CW           = 8
) (
  input logic         clk,
  input logic         reset,
  btn_repeat_if.slave bus
);

  localparam logic [CW-1:0] HoldLast   = CW'(HOLD_TICKS - 1);
  localparam logic [CW-1:0] RepeatLast = CW'(REPEAT_TICKS - 1);
  localparam bit ParamsOk = (HOLD_TICKS >= 1) && (64'(HOLD_TICKS) < (64'd1 << CW)) &&
                            (REPEAT_TICKS >= 1) && (64'(REPEAT_TICKS) < (64'd1 << CW));

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          db_q;
  logic          press_q, rel_q, rpt_q, held_q;
  logic          tick, rise, fall;

  btn_repeat_tick_gen #(
    .TICK_N (TICK_N)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign rise = bus.db & ~db_q;
  assign fall = ~bus.db & db_q;

  // db_q resets high so a button held through reset never reports a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      db_q    <= 1'b1;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      rpt_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      db_q    <= bus.db;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      rpt_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (rise) begin
            state_q <= StHold;
            cnt_q   <= '0;
            press_q <= 1'b1;
            rpt_q   <= 1'b1;
          end
        end
        StHold: begin
          if (fall) begin
            state_q <= StIdle;
            rel_q   <= 1'b1;
            cnt_q   <= '0;
          end else if (tick) begin
            if (cnt_q == HoldLast) begin
              state_q <= StRepeat;
              rpt_q   <= 1'b1;
              held_q  <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        StRepeat: begin
          // A fall on a terminal tick wins: release only, no final step.
          if (fall) begin
            state_q <= StIdle;
            rel_q   <= 1'b1;
            held_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (tick) begin
            if (cnt_q == RepeatLast) begin
              rpt_q <= 1'b1;
              cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          held_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.press = press_q;
  assign bus.rel   = rel_q;
  assign bus.rpt   = rpt_q;
  assign bus.held  = held_q;

  assert property (@(posedge clk) ParamsOk)
    else $error("btn_repeat: HOLD_TICKS/REPEAT_TICKS out of range 1..2^CW-1");

endmodule

// File: tb/tb_btn_repeat.sv
// Self-checking bench for btn_repeat: tick-count reference model compared every
// cycle, directed scenarios with literal expectations, then random button activity.
module tb_btn_repeat;

  localparam int unsigned TickN       = 2;
  localparam int unsigned HoldTicks   = 3;
  localparam int unsigned RepeatTicks = 2;
  localparam int unsigned Cw          = 8;
  localparam int          Period      = 1 << TickN;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  btn_repeat_if bus ();

  btn_repeat #(
    .TICK_N       (TickN),
    .HOLD_TICKS   (HoldTicks),
    .REPEAT_TICKS (RepeatTicks),
    .CW           (Cw)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic act, input logic expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: counts whole ticks since the press and derives every output
  // from that count; edges are taken from the previously sampled level.
  bit model_valid = 1'b0;
  bit m_pressed, m_prev_db;
  int m_ticks, m_pcount;
  bit exp_press, exp_rel, exp_rpt, exp_held;

  always @(posedge clk) begin
    bit tick, rise, fall;
    if (reset) begin
      model_valid = 1'b1;
      m_pressed = 1'b0;
      m_prev_db = 1'b1;
      m_ticks   = 0;
      m_pcount  = 0;
      exp_press = 1'b0;
      exp_rel   = 1'b0;
      exp_rpt   = 1'b0;
      exp_held  = 1'b0;
    end else begin
      tick = (m_pcount % Period) == Period - 1;
      m_pcount++;
      rise = bus.db && !m_prev_db;
      fall = !bus.db && m_prev_db;
      m_prev_db = bus.db;
      exp_press = 1'b0;
      exp_rel   = 1'b0;
      exp_rpt   = 1'b0;
      if (!m_pressed) begin
        if (rise) begin
          m_pressed = 1'b1;
          m_ticks   = 0;
          exp_press = 1'b1;
          exp_rpt   = 1'b1;
        end
      end else if (fall) begin
        m_pressed = 1'b0;
        exp_rel   = 1'b1;
      end else if (tick) begin
        m_ticks++;
        if (m_ticks >= int'(HoldTicks) && (m_ticks - int'(HoldTicks)) % int'(RepeatTicks) == 0)
          exp_rpt = 1'b1;
      end
      exp_held = m_pressed && (m_ticks >= int'(HoldTicks));
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("press", bus.press, exp_press);
      check("release", bus.rel, exp_rel);
      check("rpt", bus.rpt, exp_rpt);
      check("held", bus.held, exp_held);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic count_pulses(input int n, output int np, output int nr, output int nt);
    np = 0; nr = 0; nt = 0;
    repeat (n) begin
      @(negedge clk);
      np += int'(bus.press);
      nr += int'(bus.rel);
      nt += int'(bus.rpt);
    end
  endtask

  // Waits (bounded) until the model reports a repeat step while held.
  task automatic wait_repeat(input string name);
    bit found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      cycles(1);
      if (exp_rpt && exp_held) found = 1'b1;
    end
    check(name, found, 1'b1);
  endtask

  initial begin
    int np, nr, nt, last, quiet;
    int rq[$];
    logic held_first;

    // 1: basic press / release
    bus.db = 1'b0;
    reset  = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycles(10);
    bus.db = 1'b1;
    cycles(1);
    check("s1_press", bus.press, 1'b1);
    check("s1_rpt", bus.rpt, 1'b1);
    check("s1_model_press", exp_press, 1'b1);
    count_pulses(4, np, nr, nt);
    check_int("s1_quiet_pulses", np + nr + nt, 0);
    bus.db = 1'b0;
    cycles(1);
    check("s1_release", bus.rel, 1'b1);
    check("s1_held", bus.held, 1'b0);
    cycles(3);

    // 2: hold delay and repeat period
    bus.db = 1'b1;
    held_first = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      cycles(1);
      if (bus.rpt) begin
        if (rq.size() == 1) held_first = bus.held;
        rq.push_back(k);
      end
    end
    check("s2_enough_steps", rq.size() >= 5, 1'b1);
    if (rq.size() >= 2) begin
      check_int("s2_press_step", rq[0], 1);
      check("s2_first_delay_range", (rq[1] - 1 >= 9) && (rq[1] - 1 <= 12), 1'b1);
      check("s2_held_with_first", held_first, 1'b1);
      for (int i = 2; i < rq.size(); i++) check_int("s2_period", rq[i] - rq[i-1], 8);
    end
    bus.db = 1'b0;
    cycles(1);
    check("s2_release", bus.rel, 1'b1);
    check("s2_held_cleared", bus.held, 1'b0);
    count_pulses(20, np, nr, nt);
    check_int("s2_no_more_rpt", nt, 0);

    // 3: fall on the same edge as a terminal repeat tick
    bus.db = 1'b1;
    wait_repeat("s3_reached_repeat");
    cycles(int'(RepeatTicks) * Period - 1);
    bus.db = 1'b0;
    cycles(1);
    check("s3_release", bus.rel, 1'b1);
    check("s3_no_rpt", bus.rpt, 1'b0);
    check("s3_model_no_rpt", exp_rpt, 1'b0);
    count_pulses(20, np, nr, nt);
    check_int("s3_idle_after", np + nr + nt, 0);

    // 4: reset mid-repeat with the button still down
    bus.db = 1'b1;
    wait_repeat("s4_reached_repeat");
    cycles(2);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    check("s4_press0", bus.press, 1'b0);
    check("s4_rel0", bus.rel, 1'b0);
    check("s4_rpt0", bus.rpt, 1'b0);
    check("s4_held0", bus.held, 1'b0);
    count_pulses(6, np, nr, nt);
    check_int("s4_no_press", np, 0);
    bus.db = 1'b0;
    count_pulses(3, np, nr, nt);
    check_int("s4_no_release", nr, 0);
    bus.db = 1'b1;
    cycles(1);
    check("s4_press", bus.press, 1'b1);
    check("s4_rpt", bus.rpt, 1'b1);
    bus.db = 1'b0;
    cycles(3);

    // 5: button already down through reset
    reset  = 1'b1;
    bus.db = 1'b1;
    cycles(2);
    reset = 1'b0;
    count_pulses(6, np, nr, nt);
    check_int("s5_no_press", np, 0);
    bus.db = 1'b0;
    cycles(2);
    bus.db = 1'b1;
    count_pulses(6, np, nr, nt);
    check_int("s5_one_press", np, 1);
    bus.db = 1'b0;
    cycles(3);

    // 6: long idle run across many prescaler wraps
    last  = -1;
    quiet = 0;
    for (int k = 0; k < 1000; k++) begin
      cycles(1);
      quiet += int'(bus.press) + int'(bus.rel) + int'(bus.rpt);
      if (dut.u_tick_gen.tick) begin
        if (last >= 0) check_int("s6_tick_period", k - last, Period);
        last = k;
      end
    end
    check_int("s6_no_pulses", quiet, 0);

    // Random button activity with occasional resets
    for (int seg = 0; seg < 200; seg++) begin
      bus.db = 1'($urandom_range(0, 1));
      reset  = ($urandom_range(0, 39) == 0);
      cycles(1);
      reset = 1'b0;
      cycles($urandom_range(0, 35));
    end
    cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
